lwe_op_sequencer: RTL and testbench

Parametrised address/beat sequencer for the LWE ciphertext datapath. It accepts one operation descriptor through a valid/ready handshake: opcode, three base addresses and a runtime vector length. It then walks the operand and result memories LANES elements per beat, driving the encrypt/decrypt/add/mult datapath enables. It adds stall back-pressure, abort, a runtime length, multi-lane stepping and a clean single-cycle done pulse.

---
 rtl/lwe_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_lwe_op_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lwe_op_sequencer.sv
// lwe_op_sequencer: address/beat sequencer for the LWE ciphertext datapath.
// Accepts one descriptor (cfg_valid/cfg_ready), then walks op1/op2/out
// memories LANES elements per beat, driving en/row/op_select to the datapath.
// Ports: clk, rst_n (sync, active-low); cfg_valid/cfg_ready, opcode,
// op1_base/op2_base/out_base, length; stall, abort; opcode_out, op1_addr,
// op2_addr, out_addr, row, op_select, en, busy, done.
module lwe_op_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 6,
  parameter int ROW_WIDTH  = 7,
  parameter int LANES      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] op1_base,
  input  logic [ADDR_WIDTH-1:0] op2_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  stall,
  input  logic                  abort,
  output logic [1:0]            opcode_out,
  output logic [ADDR_WIDTH-1:0] op1_addr,
  output logic [ADDR_WIDTH-1:0] op2_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ROW_WIDTH-1:0]  row,
  output logic                  op_select,
  output logic                  en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MULT2,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_MULT = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(LANES);
  localparam logic [LEN_WIDTH-1:0]  L_ONE = LEN_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0]  R_ONE = ROW_WIDTH'(1);

  state_t                state_q;
  logic [1:0]            opcode_q;
  logic [ADDR_WIDTH-1:0] op1_q, op2_q, out_q;
  logic [ROW_WIDTH-1:0]  row_q;
  logic [LEN_WIDTH-1:0]  cnt_q, len_q;
  logic                  sel_q, en_q, done_q;

  logic last_beat;
  logic is_mult;

  assign last_beat = (cnt_q == len_q - L_ONE);
  assign is_mult   = (opcode_q == OP_MULT);

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign opcode_out = opcode_q;
  assign op1_addr   = op1_q;
  assign op2_addr   = op2_q;
  assign out_addr   = out_q;
  assign row        = row_q;
  assign op_select  = sel_q;
  assign en         = en_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      out_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            opcode_q <= opcode;
            len_q    <= length;
            op1_q    <= op1_base;
            op2_q    <= op2_base;
            out_q    <= out_base;
            row_q    <= '0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            if (length != '0) begin
              state_q <= S_RUN;
              en_q    <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN, S_MULT2: begin
          if (abort) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            sel_q   <= 1'b0;
          end else if (!stall) begin
            if (!last_beat) begin
              cnt_q <= cnt_q + L_ONE;
              if (opcode_q == OP_ADD) begin
                op1_q <= op1_q + STEP;
                op2_q <= op2_q + STEP;
                out_q <= out_q + STEP;
              end else if (!is_mult) begin
                op1_q <= op1_q + STEP;
                op2_q <= op2_q + STEP;
                row_q <= row_q + R_ONE;
              end else if (state_q == S_RUN) begin
                op1_q <= op1_q + STEP;
                out_q <= out_q + STEP;
                row_q <= row_q + R_ONE;
              end else begin
                op2_q <= op2_q + STEP;
                out_q <= out_q + STEP;
                row_q <= row_q + R_ONE;
              end
            end else if (state_q == S_RUN && is_mult) begin
              // second MULT sweep: op2 still sits at its base
              state_q <= S_MULT2;
              sel_q   <= 1'b1;
              cnt_q   <= '0;
              out_q   <= out_q + STEP;
              row_q   <= row_q + R_ONE;
            end else begin
              state_q <= S_DONE;
              en_q    <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lwe_op_sequencer.sv
// tb_lwe_op_sequencer: directed self-checking bench for lwe_op_sequencer.
// Two instances share stimulus: LANES=1 and LANES=4.
module tb_lwe_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [1:0] opcode;
  logic [9:0] op1_base, op2_base, out_base;
  logic [5:0] length;
  logic       stall, abort;

  logic       rdy1, sel1, en1, busy1, done1;
  logic [1:0] opc1;
  logic [9:0] a1_1, a2_1, ao_1;
  logic [6:0] row1;

  logic       rdy4, sel4, en4, busy4, done4;
  logic [1:0] opc4;
  logic [9:0] a1_4, a2_4, ao_4;
  logic [6:0] row4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lwe_op_sequencer #(.LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .opcode(opcode), .op1_base(op1_base),
    .op2_base(op2_base), .out_base(out_base),
    .length(length), .stall(stall), .abort(abort),
    .opcode_out(opc1), .op1_addr(a1_1),
    .op2_addr(a2_1), .out_addr(ao_1),
    .row(row1), .op_select(sel1), .en(en1),
    .busy(busy1), .done(done1)
  );

  lwe_op_sequencer #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(rdy4),
    .opcode(opcode), .op1_base(op1_base),
    .op2_base(op2_base), .out_base(out_base),
    .length(length), .stall(stall), .abort(abort),
    .opcode_out(opc4), .op1_addr(a1_4),
    .op2_addr(a2_4), .out_addr(ao_4),
    .row(row4), .op_select(sel4), .en(en4),
    .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] op,
                       input logic [9:0] b1,
                       input logic [5:0] len);
    opcode    = op;
    op1_base  = b1;
    op2_base  = 10'h100;
    out_base  = 10'h200;
    length    = len;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin : stim
    logic [9:0] m_op1 [6];
    logic [9:0] m_op2 [6];
    logic       m_sel [6];
    logic [9:0] w_op1 [4];

    m_op1 = '{10'h010, 10'h011, 10'h012,
              10'h012, 10'h012, 10'h012};
    m_op2 = '{10'h100, 10'h100, 10'h100,
              10'h100, 10'h101, 10'h102};
    m_sel = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    w_op1 = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};

    rst_n = 1'b0;
    cfg_valid = 1'b0;
    opcode = 2'd0;
    op1_base = '0;
    op2_base = '0;
    out_base = '0;
    length = '0;
    stall = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    chk("rst_ready", rdy1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_en", en1, 0);
    chk("rst_done", done1, 0);
    chk("rst_op1", a1_1, 0);
    chk("rst_row", row1, 0);
    rst_n = 1'b1;
    tick();

    // ENC length 4
    start(2'd0, 10'h010, 6'd4);
    for (int k = 0; k < 4; k++) begin
      chk("enc_en", en1, 1);
      chk("enc_op1", a1_1, 32'h010 + k);
      chk("enc_op2", a2_1, 32'h100 + k);
      chk("enc_out", ao_1, 32'h200);
      chk("enc_row", row1, k);
      chk("enc_done0", done1, 0);
      tick();
    end
    chk("enc_done", done1, 1);
    chk("enc_en_off", en1, 0);
    tick();
    chk("enc_ready", rdy1, 1);
    chk("enc_done_clr", done1, 0);

    // MULT length 3
    start(2'd3, 10'h010, 6'd3);
    for (int k = 0; k < 6; k++) begin
      chk("mul_en", en1, 1);
      chk("mul_sel", sel1, m_sel[k]);
      chk("mul_op1", a1_1, m_op1[k]);
      chk("mul_op2", a2_1, m_op2[k]);
      chk("mul_out", ao_1, 32'h200 + k);
      chk("mul_row", row1, k);
      tick();
    end
    chk("mul_done", done1, 1);
    chk("mul_en_off", en1, 0);
    tick();

    // ADD length 3, stall during cycles 2-3
    start(2'd2, 10'h010, 6'd3);
    chk("add_c1_op1", a1_1, 32'h010);
    tick();
    stall = 1'b1;
    chk("add_c2_op1", a1_1, 32'h011);
    tick();
    chk("add_c3_op1", a1_1, 32'h011);
    chk("add_c3_op2", a2_1, 32'h101);
    chk("add_c3_out", ao_1, 32'h201);
    chk("add_c3_en", en1, 1);
    chk("add_c3_row", row1, 0);
    tick();
    stall = 1'b0;
    chk("add_c4_op1", a1_1, 32'h011);
    chk("add_c4_en", en1, 1);
    tick();
    chk("add_c5_op1", a1_1, 32'h012);
    chk("add_c5_done", done1, 0);
    tick();
    chk("add_c6_done", done1, 1);
    tick();

    // LANES=4 wrap, ADD length 4
    start(2'd2, 10'h3F8, 6'd4);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_en", en4, 1);
      chk("wrap_op1", a1_4, w_op1[k]);
      chk("wrap_out", ao_4, 32'h200 + 4 * k);
      tick();
    end
    chk("wrap_done", done4, 1);
    tick();

    // length 0, ignored cfg while busy
    start(2'd1, 10'h010, 6'd0);
    chk("len0_done", done1, 1);
    chk("len0_en", en1, 0);
    chk("len0_opc", opc1, 1);
    opcode = 2'd3;
    length = 6'd5;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("len0_done_clr", done1, 0);
    chk("len0_en2", en1, 0);
    chk("len0_ready", rdy1, 1);
    chk("len0_opc_keep", opc1, 1);
    tick();

    // abort at cycle 2 of ENC length 8
    start(2'd0, 10'h010, 6'd8);
    tick();
    abort = 1'b1;
    chk("abt_c2_en", en1, 1);
    tick();
    abort = 1'b0;
    chk("abt_en", en1, 0);
    chk("abt_ready", rdy1, 1);
    chk("abt_done", done1, 0);
    chk("abt_op1_hold", a1_1, 32'h011);
    tick();
    chk("abt_done2", done1, 0);

    // reset mid-MULT
    start(2'd3, 10'h010, 6'd3);
    tick();
    tick();
    tick();
    chk("rmid_sel", sel1, 1);
    rst_n = 1'b0;
    tick();
    chk("rmid_op1", a1_1, 0);
    chk("rmid_op2", a2_1, 0);
    chk("rmid_out", ao_1, 0);
    chk("rmid_row", row1, 0);
    chk("rmid_sel0", sel1, 0);
    chk("rmid_en", en1, 0);
    chk("rmid_done", done1, 0);
    chk("rmid_opc", opc1, 0);
    chk("rmid_busy", busy1, 0);
    chk("rmid_ready", rdy1, 1);
    rst_n = 1'b1;
    tick();
    chk("rmid_done2", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
